// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Arbitrates three requesters (instruction fetch i, data d, debug g) onto a
//   single external memory bus. One access is in flight at a time; each access
//   walks IDLE -> ACCESS -> RESP, so back-to-back accesses issue at most once
//   every three cycles. Debug always wins; i and d share the bus round-robin.
//   While dbg_halt is high only the debug requester can be granted.
//
// Parameters
//   TIMEOUT  ACCESS cycles without mem_din_ready before the access is aborted
//            (only meaningful when MEM_ARB_TIMEOUT_EN is defined)
//   DATA_W   data path width (64)
//
// Configuration macro
//   MEM_ARB_TIMEOUT_EN  enables the ACCESS watchdog; an expired access finishes
//                       with err=1 and rdata=0. Undefined: ACCESS waits forever
//                       and err is tied low.
//
// Ports
//   clk, rst_n                        clock, asynchronous active-low reset
//   dbg_halt                          CPU halted by debug
//   {i,d,g}_req/addr/wdata/we/width   requester access descriptors
//   {i,d,g}_done                      one-cycle completion pulse to the owner
//   rdata, err                        read data / abort flag, valid with *_done
//   mem_addr, mem_dout, mem_width     external bus address / write data / width
//   mem_addr_valid, mem_dout_write    external access in progress / write strobe
//   mem_din, mem_din_ready            external read data / access complete
module mem_bus_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int DATA_W  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dbg_halt,
  input  logic              i_req,
  input  logic              d_req,
  input  logic              g_req,
  input  logic [63:0]       i_addr,
  input  logic [63:0]       d_addr,
  input  logic [63:0]       g_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [DATA_W-1:0] g_wdata,
  input  logic              i_we,
  input  logic              d_we,
  input  logic              g_we,
  input  logic [1:0]        i_width,
  input  logic [1:0]        d_width,
  input  logic [1:0]        g_width,
  output logic              i_done,
  output logic              d_done,
  output logic              g_done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [63:0]       mem_addr,
  output logic [DATA_W-1:0] mem_dout,
  output logic [1:0]        mem_width,
  output logic              mem_addr_valid,
  output logic              mem_dout_write,
  input  logic [DATA_W-1:0] mem_din,
  input  logic              mem_din_ready
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D, OWN_G} owner_t;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_bus_arbiter: TIMEOUT must be at least 1");
  end

  state_t            state_q, state_d;
  owner_t            gnt, owner_q;
  logic              rr_prefer_d;
  logic [63:0]       acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_we;
  logic [1:0]        acc_width;
  logic              timeout_hit;
  logic              abort_q;

  // Winner among current requests; only consulted in IDLE.
  always_comb begin
    gnt = OWN_NONE;
    if (g_req) begin
      gnt = OWN_G;
    end else if (!dbg_halt) begin
      if (i_req && d_req) gnt = rr_prefer_d ? OWN_D : OWN_I;
      else if (i_req)     gnt = OWN_I;
      else if (d_req)     gnt = OWN_D;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (gnt != OWN_NONE) state_d = S_ACCESS;
      S_ACCESS: if (mem_din_ready || timeout_hit) state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Owner, round-robin pointer and read-data capture. A completing ready wins
  // over a coincident timeout; writes and aborts return zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= OWN_NONE;
      rr_prefer_d <= 1'b1;
      rdata       <= '0;
    end else begin
      if (state_q == S_IDLE && gnt != OWN_NONE) begin
        owner_q <= gnt;
        if (gnt == OWN_I)      rr_prefer_d <= 1'b1;
        else if (gnt == OWN_D) rr_prefer_d <= 1'b0;
      end
      if (state_q == S_ACCESS && (mem_din_ready || timeout_hit))
        rdata <= (acc_we || !mem_din_ready) ? '0 : mem_din;
    end
  end

  // Access descriptor latch; only observed through the ACCESS-state outputs,
  // so it carries no reset.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE) begin
      case (gnt)
        OWN_I: begin
          acc_addr <= i_addr; acc_wdata <= i_wdata; acc_we <= i_we; acc_width <= i_width;
        end
        OWN_D: begin
          acc_addr <= d_addr; acc_wdata <= d_wdata; acc_we <= d_we; acc_width <= d_width;
        end
        OWN_G: begin
          acc_addr <= g_addr; acc_wdata <= g_wdata; acc_we <= g_we; acc_width <= g_width;
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  logic [CNT_W-1:0] tmo_cnt;

  // Counter reads k-1 during the k-th ACCESS cycle.
  assign timeout_hit = (state_q == S_ACCESS) && !mem_din_ready &&
                       (tmo_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      abort_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE)        tmo_cnt <= '0;
      else if (state_q == S_ACCESS) tmo_cnt <= tmo_cnt + CNT_W'(1);
      if (state_q == S_ACCESS)      abort_q <= timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign abort_q     = 1'b0;
`endif

  always_comb begin
    mem_addr_valid = 1'b0;
    mem_dout_write = 1'b0;
    mem_addr       = '0;
    mem_dout       = '0;
    mem_width      = '0;
    i_done         = 1'b0;
    d_done         = 1'b0;
    g_done         = 1'b0;
    err            = 1'b0;
    case (state_q)
      S_ACCESS: begin
        mem_addr_valid = 1'b1;
        mem_dout_write = acc_we;
        mem_addr       = acc_addr;
        mem_dout       = acc_wdata;
        mem_width      = acc_width;
      end
      S_RESP: begin
        i_done = (owner_q == OWN_I);
        d_done = (owner_q == OWN_D);
        g_done = (owner_q == OWN_G);
        err    = abort_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Directed bench for mem_bus_arbiter. Inputs change and outputs are sampled
//   1 time unit after each rising clock edge; the DUT has no combinational
//   input-to-output paths, so the sampled values reflect the state just
//   entered. Build with MEM_ARB_TIMEOUT_EN to exercise the watchdog (TIMEOUT=4).
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dbg_halt;
  logic        i_req, d_req, g_req;
  logic [63:0] i_addr, d_addr, g_addr;
  logic [63:0] i_wdata, d_wdata, g_wdata;
  logic        i_we, d_we, g_we;
  logic [1:0]  i_width, d_width, g_width;
  logic        i_done, d_done, g_done;
  logic [63:0] rdata;
  logic        err;
  logic [63:0] mem_addr, mem_dout;
  logic [1:0]  mem_width;
  logic        mem_addr_valid, mem_dout_write;
  logic [63:0] mem_din;
  logic        mem_din_ready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT(4), .DATA_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .dbg_halt(dbg_halt),
    .i_req(i_req), .d_req(d_req), .g_req(g_req),
    .i_addr(i_addr), .d_addr(d_addr), .g_addr(g_addr),
    .i_wdata(i_wdata), .d_wdata(d_wdata), .g_wdata(g_wdata),
    .i_we(i_we), .d_we(d_we), .g_we(g_we),
    .i_width(i_width), .d_width(d_width), .g_width(g_width),
    .i_done(i_done), .d_done(d_done), .g_done(g_done),
    .rdata(rdata), .err(err),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_width(mem_width),
    .mem_addr_valid(mem_addr_valid), .mem_dout_write(mem_dout_write),
    .mem_din(mem_din), .mem_din_ready(mem_din_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packs the three done pulses as {g,d,i} for one-shot comparison.
  function automatic logic [63:0] dones();
    return {61'd0, g_done, d_done, i_done};
  endfunction

  initial begin
    rst_n = 1'b0; dbg_halt = 1'b0;
    i_req = 0; d_req = 0; g_req = 0;
    i_addr = '0; d_addr = '0; g_addr = '0;
    i_wdata = '0; d_wdata = '0; g_wdata = '0;
    i_we = 0; d_we = 0; g_we = 0;
    i_width = '0; d_width = '0; g_width = '0;
    mem_din = '0; mem_din_ready = 1'b0;

    tick(); tick();
    check("rst_valid", mem_addr_valid, 0);
    check("rst_write", mem_dout_write, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_rdata", rdata, 0);
    check("rst_err", err, 0);
    check("rst_dones", dones(), 0);
    rst_n = 1'b1;
    tick();

    // i and d together: pointer starts preferring d.
    i_req = 1; i_addr = 64'h100; d_req = 1; d_addr = 64'h200;
    tick();
    check("rr1_valid", mem_addr_valid, 1);
    check("rr1_addr_d", mem_addr, 64'h200);
    mem_din = 64'hD0; mem_din_ready = 1;
    tick();
    check("rr1_done_d", dones(), 3'b010);
    check("rr1_rdata", rdata, 64'hD0);
    mem_din_ready = 0; d_req = 0;
    tick();
    check("rr1_idle_dones", dones(), 0);
    tick();
    check("rr2_addr_i", mem_addr, 64'h100);
    mem_din = 64'h11; mem_din_ready = 1;
    tick();
    check("rr2_done_i", dones(), 3'b001);
    mem_din_ready = 0; d_req = 1;      // both pending again, pointer now prefers d
    tick(); tick();
    check("rr3_addr_d", mem_addr, 64'h200);
    mem_din_ready = 1;
    tick();
    check("rr3_done_d", dones(), 3'b010);
    mem_din_ready = 0; d_req = 0;
    tick(); tick();
    check("rr4_addr_i", mem_addr, 64'h100);
    mem_din_ready = 1;
    tick();
    check("rr4_done_i", dones(), 3'b001);
    mem_din_ready = 0; i_req = 0;
    tick();

    // g arrives while d is in ACCESS; d finishes, g beats pending i.
    d_req = 1; d_addr = 64'h300;
    tick();
    g_req = 1; g_addr = 64'h400; i_req = 1; i_addr = 64'h180;
    tick();
    check("g_wait_addr", mem_addr, 64'h300);
    check("g_wait_dones", dones(), 0);
    mem_din = 64'h33; mem_din_ready = 1;
    tick();
    check("g_d_done", dones(), 3'b010);
    mem_din_ready = 0; d_req = 0;
    tick(); tick();
    check("g_granted", mem_addr, 64'h400);
    mem_din = 64'h44; mem_din_ready = 1;
    tick();
    check("g_done", dones(), 3'b100);
    check("g_rdata", rdata, 64'h44);
    mem_din_ready = 0; g_req = 0;
    tick(); tick();
    check("g_then_i", mem_addr, 64'h180);
    mem_din_ready = 1;
    tick();
    check("g_then_i_done", dones(), 3'b001);
    mem_din_ready = 0; i_req = 0;
    tick();

    // dbg_halt: only g granted, i waits.
    dbg_halt = 1; i_req = 1; i_addr = 64'h1C0; g_req = 1; g_addr = 64'h500;
    tick();
    check("halt_g_addr", mem_addr, 64'h500);
    mem_din_ready = 1;
    tick();
    check("halt_g_done", dones(), 3'b100);
    mem_din_ready = 0; g_req = 0;
    tick(); tick();
    check("halt_i_blocked", mem_addr_valid, 0);
    tick();
    check("halt_i_blocked2", mem_addr_valid, 0);
    dbg_halt = 0;
    tick();
    check("unhalt_i_addr", mem_addr, 64'h1C0);
    mem_din_ready = 1;
    tick();
    check("unhalt_i_done", dones(), 3'b001);
    mem_din_ready = 0; i_req = 0;
    tick();

    // d write; descriptor stable until ready, write returns rdata 0.
    d_req = 1; d_addr = 64'h8000_0000_0000_0010; d_wdata = 64'hDEADBEEF; d_we = 1; d_width = 2'd3;
    tick();
    check("wr_strobe", mem_dout_write, 1);
    check("wr_addr", mem_addr, 64'h8000_0000_0000_0010);
    check("wr_dout", mem_dout, 64'hDEADBEEF);
    check("wr_width", mem_width, 3);
    tick();
    check("wr_addr_hold", mem_addr, 64'h8000_0000_0000_0010);
    check("wr_dout_hold", mem_dout, 64'hDEADBEEF);
    mem_din = 64'h5555; mem_din_ready = 1;
    tick();
    check("wr_done", dones(), 3'b010);
    check("wr_rdata_zero", rdata, 0);
    check("wr_resp_strobe", mem_dout_write, 0);
    check("wr_resp_valid", mem_addr_valid, 0);
    mem_din_ready = 0; d_req = 0; d_we = 0;
    tick();

    // i read; ready at edge N -> data and done in cycle N+1, held afterwards.
    i_req = 1; i_addr = 64'h2000; i_we = 0; i_width = 2'd2;
    tick();
    check("rd_strobe", mem_dout_write, 0);
    check("rd_width", mem_width, 2);
    mem_din = 64'h0123456789ABCDEF; mem_din_ready = 1;
    tick();
    check("rd_done", dones(), 3'b001);
    check("rd_rdata", rdata, 64'h0123456789ABCDEF);
    check("rd_err", err, 0);
    mem_din_ready = 0; i_req = 0; mem_din = 64'hFFFF;
    tick();
    check("rd_done_once", dones(), 0);
    check("rd_rdata_hold", rdata, 64'h0123456789ABCDEF);

    // Ready outside ACCESS is ignored.
    mem_din_ready = 1;
    tick(); tick();
    check("idle_ready_rdata", rdata, 64'h0123456789ABCDEF);
    check("idle_ready_dones", dones(), 0);
    mem_din_ready = 0;

    // Reset mid-ACCESS: outputs drop at once, no done afterwards.
    d_req = 1; d_addr = 64'h600;
    tick();
    check("mid_valid", mem_addr_valid, 1);
    rst_n = 0;
    #1;
    check("mid_rst_valid", mem_addr_valid, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_rdata", rdata, 0);
    d_req = 0;
    tick();
    rst_n = 1; mem_din_ready = 1;
    tick();
    check("mid_no_done1", dones(), 0);
    tick();
    check("mid_no_done2", dones(), 0);
    mem_din_ready = 0;
    tick();

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog with TIMEOUT=4: four ACCESS cycles, then abort.
    i_req = 1; i_addr = 64'h700; mem_din = 64'hABCD;
    tick();
    tick(); tick(); tick();
    check("tmo_access4", mem_addr_valid, 1);
    tick();
    check("tmo_done", dones(), 3'b001);
    check("tmo_err", err, 1);
    check("tmo_rdata", rdata, 0);
    i_req = 0;
    tick();
    check("tmo_err_clear", err, 0);
`else
    // Without the watchdog ACCESS waits indefinitely.
    i_req = 1; i_addr = 64'h700;
    for (int k = 0; k < 10; k++) tick();
    check("notmo_still_valid", mem_addr_valid, 1);
    check("notmo_no_done", dones(), 0);
    mem_din = 64'h77; mem_din_ready = 1;
    tick();
    check("notmo_done", dones(), 3'b001);
    check("notmo_err", err, 0);
    mem_din_ready = 0; i_req = 0;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
